filter_sequencer: RTL and testbench

FILTER_SEQUENCER -- requirements
Module: filter_sequencer

---
 rtl/filter_sequencer_if.sv | 28 ++
 rtl/filter_sequencer.sv | 166 ++++++++++++++++
 tb/tb_filter_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/filter_sequencer_if.sv
// filter_sequencer_if: sample/result bundle for the FIR sequencer.
//   inSignal  - new input sample (signed, DATA_W bits), valid with newData
//   newData   - single-cycle sample strobe
//   outSignal - registered filtered sample (signed, DATA_W bits)
//   dataReady - one-cycle pulse when outSignal is updated
//   busy      - filter is computing (not idle)
//   overrun   - sticky: a strobe was dropped while busy
// master drives samples, slave (the filter) returns results.
interface filter_sequencer_if #(
  parameter int DATA_W = 18
);
  logic signed [DATA_W-1:0] inSignal;
  logic                     newData;
  logic signed [DATA_W-1:0] outSignal;
  logic                     dataReady;
  logic                     busy;
  logic                     overrun;

  modport master (
    output inSignal, newData,
    input  outSignal, dataReady, busy, overrun
  );

  modport slave (
    input  inSignal, newData,
    output outSignal, dataReady, busy, overrun
  );
endinterface

// File: rtl/filter_sequencer.sv
// filter_sequencer: 11-tap symmetric FIR using a single shared multiplier.
// A sample strobe shifts the delay line, then six multiply-accumulate steps
// fold the symmetric tap pairs, and a final step rounds toward minus infinity,
// saturates and publishes the result with a one-cycle dataReady pulse.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - filter_sequencer_if slave (inSignal/newData in;
//          outSignal/dataReady/busy/overrun out)
module filter_sequencer #(
  parameter int DATA_W = 18,
  parameter int FRAC_W = 12
) (
  input logic                clk,
  input logic                rst,
  filter_sequencer_if.slave  bus
);

  localparam int COEF_W = 13;                  // 12-bit magnitude + sign
  localparam int PAIR_W = DATA_W + 1;
  localparam int PROD_W = PAIR_W + COEF_W;
  localparam int ACC_W  = (PROD_W + 8 > 40) ? PROD_W + 8 : 40;
  localparam int NTAPS  = 11;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t                   state_q;
  logic [2:0]               k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] d_q [NTAPS];
  logic signed [DATA_W-1:0] out_q;
  logic                     ready_q;
  logic                     busy_q;
  logic                     overrun_q;

  logic [3:0]               lo_idx;
  logic [3:0]               hi_idx;
  logic signed [DATA_W-1:0] tap_lo;
  logic signed [DATA_W-1:0] tap_hi;
  logic signed [PAIR_W-1:0] pair;
  logic [COEF_W-2:0]        coef_mag;
  logic                     coef_neg;
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] out_d;

  // Coefficient table; magnitude is unsigned, sign selects add/subtract.
  always_comb begin
    coef_mag = '0;
    coef_neg = 1'b0;
    case (k_q)
      3'd0: begin coef_mag = 12'h050; coef_neg = 1'b0; end
      3'd1: begin coef_mag = 12'h1D3; coef_neg = 1'b1; end
      3'd2: begin coef_mag = 12'h041; coef_neg = 1'b0; end
      3'd3: begin coef_mag = 12'h0AE; coef_neg = 1'b1; end
      3'd4: begin coef_mag = 12'h2DB; coef_neg = 1'b1; end
      3'd5: begin coef_mag = 12'h9D0; coef_neg = 1'b0; end
      default: begin coef_mag = '0; coef_neg = 1'b0; end
    endcase
    coef = $signed({1'b0, coef_mag});
  end

  // Symmetric pair operand; the centre tap (k=5) has no partner.
  always_comb begin
    lo_idx = {1'b0, k_q};
    hi_idx = 4'd10 - lo_idx;
    tap_lo = d_q[lo_idx];
    tap_hi = d_q[hi_idx];
    if (k_q == 3'd5) begin
      pair = {tap_lo[DATA_W-1], tap_lo};
    end else begin
      pair = {tap_lo[DATA_W-1], tap_lo} + {tap_hi[DATA_W-1], tap_hi};
    end
  end

  // The one shared multiplier and the accumulate step.
  always_comb begin
    prod     = PROD_W'(pair) * PROD_W'(coef);
    prod_ext = ACC_W'(prod);
    acc_d    = coef_neg ? (acc_q - prod_ext) : (acc_q + prod_ext);
  end

  // Arithmetic shift truncates toward minus infinity, then saturate.
  always_comb begin
    shifted = acc_q >>> FRAC_W;
    if (shifted > SAT_MAX) begin
      out_d = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      out_d = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      out_d = shifted[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b0;
      // Strobes during MAC/OUT are dropped and flagged.
      if (bus.newData && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.newData) begin
            for (int unsigned i = NTAPS - 1; i > 0; i--) begin
              d_q[i] <= d_q[i-1];
            end
            d_q[0]  <= bus.inSignal;
            acc_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (k_q == 3'd5) begin
            k_q     <= '0;
            state_q <= OUT;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        OUT: begin
          out_q   <= out_d;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.outSignal = out_q;
  assign bus.dataReady = ready_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_filter_sequencer.sv
// tb_filter_sequencer: directed vectors for the 11-tap FIR sequencer.
module tb_filter_sequencer;

  logic clk;
  logic rst;

  filter_sequencer_if #(.DATA_W(18)) bus ();

  filter_sequencer #(
    .DATA_W(18),
    .FRAC_W(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [17:0] din;
    int                 gap;   // cycles from this strobe to the next
    bit                 chk;   // compare outSignal for this sample
    int                 expv;
  } vec_t;

  int tests_run;
  int tests_failed;
  logic signed [17:0] last_out;
  bit                 last_known;

  vec_t imp_v [12];
  vec_t dc_v  [14];
  vec_t sat_v [11];

  task automatic check(input string name, input longint act, input longint req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic strobe(input logic signed [17:0] x);
    @(negedge clk);
    bus.inSignal = x;
    bus.newData  = 1'b1;
    @(posedge clk);
    #1;
    bus.newData  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_out   = '0;
    last_known = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    lat = 0;
    strobe(v.din);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (c == 6 && last_known) check({name, "_hold"}, bus.outSignal, last_out);
      if (bus.dataReady) begin
        lat = c;
        break;
      end
    end
    check({name, "_latency"}, lat, 7);
    if (v.chk) begin
      check({name, "_out"}, bus.outSignal, v.expv);
      last_out   = 18'(v.expv);
      last_known = 1'b1;
    end else begin
      last_known = 1'b0;
    end
    check({name, "_overrun"}, bus.overrun, 0);
    if (v.gap > 8) repeat (v.gap - 8) @(posedge clk);
  endtask

  initial begin
    int imp_exp [12] = '{80, -467, 65, -174, -731, 2512, -731, -174, 65, -467, 80, 0};
    int sgn [11]     = '{1, -1, 1, -1, -1, 1, -1, -1, 1, -1, 1};
    int pulses;
    int rdy_at;
    logic signed [17:0] captured;

    tests_run    = 0;
    tests_failed = 0;
    last_out     = '0;
    last_known   = 1'b0;

    for (int i = 0; i < 12; i++) begin
      imp_v[i].din  = (i == 0) ? 18'sd4096 : 18'sd0;
      imp_v[i].gap  = 8;
      imp_v[i].chk  = 1'b1;
      imp_v[i].expv = imp_exp[i];
    end
    for (int i = 0; i < 14; i++) begin
      dc_v[i].din  = 18'sd4096;
      dc_v[i].gap  = 10;
      dc_v[i].chk  = (i >= 10);
      dc_v[i].expv = 58;
    end
    for (int i = 0; i < 11; i++) begin
      sat_v[i].din  = 18'(sgn[i] * 131071);
      sat_v[i].gap  = 8;
      sat_v[i].chk  = (i == 10);
      sat_v[i].expv = 131071;
    end

    rst          = 1'b1;
    bus.inSignal = '0;
    bus.newData  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out", bus.outSignal, 0);
    check("rst_ready", bus.dataReady, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    last_out   = '0;
    last_known = 1'b1;

    // Impulse, DC and saturation tables run back to back.
    for (int i = 0; i < 12; i++) run_vec(imp_v[i], $sformatf("imp%0d", i));
    for (int i = 0; i < 14; i++) run_vec(dc_v[i], $sformatf("dc%0d", i));
    for (int i = 0; i < 11; i++) run_vec(sat_v[i], $sformatf("sat%0d", i));

    // Asynchronous reset asserted between clock edges.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out", bus.outSignal, 0);
    check("arst_ready", bus.dataReady, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_overrun", bus.overrun, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.dataReady) pulses++;
    end
    check("arst_no_ready", pulses, 0);

    // Reset in the middle of a computation.
    strobe(18'sd4096);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.dataReady) pulses++;
    end
    check("midrst_no_ready", pulses, 0);
    check("midrst_out", bus.outSignal, 0);
    last_out   = '0;
    last_known = 1'b1;
    begin
      vec_t v;
      v.din = 18'sd4096; v.gap = 8; v.chk = 1'b1; v.expv = 80;
      run_vec(v, "midrst_imp");
    end

    // Overrun: second strobe at T+3 is dropped.
    do_reset();
    pulses   = 0;
    rdy_at   = 0;
    captured = '0;
    strobe(18'sd4096);
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk);
      #1;
      if (bus.dataReady) begin pulses++; rdy_at = c; captured = bus.outSignal; end
    end
    strobe(18'sd8192);
    check("ovr_flag_set", bus.overrun, 1);
    check("ovr_busy", bus.busy, 1);
    if (bus.dataReady) begin pulses++; rdy_at = 3; captured = bus.outSignal; end
    for (int c = 4; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (bus.dataReady) begin pulses++; rdy_at = c; captured = bus.outSignal; end
    end
    check("ovr_pulses", pulses, 1);
    check("ovr_latency", rdy_at, 7);
    check("ovr_out", captured, 80);
    repeat (20) @(posedge clk);
    #1;
    check("ovr_sticky", bus.overrun, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
